// File: rtl/sata_oob_pkg.sv
// Shared SATA OOB definitions: FSM state encoding, timeout cycle arithmetic
// and retry counter width, reused by the host controller, coder and detector.
package sata_oob_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RST_SEND,
        RST_WAIT,
        INIT_WAIT,
        WAKE_SEND,
        WAKE_WAIT,
        DEV_WAKE,
        ALIGN_WAIT,
        LINKUP
    } oob_state_t;

    localparam int RETRY_W = 8;

    // Bit positions of the two timeout flags reported by sata_oob_timer.
    localparam int TMO_INIT  = 0;
    localparam int TMO_ALIGN = 1;

    // Rounded cycle count for a timeout given in microseconds at a kHz clock.
    function automatic int unsigned tmo_cycles(input int unsigned clkfreq_khz,
                                               input int unsigned tmo_us);
        longint unsigned prod;
        prod = 64'(clkfreq_khz) * 64'(tmo_us) + 64'd500;
        return 32'(prod / 64'd1000);
    endfunction

endpackage

// File: rtl/sata_oob_timer.sv
// Single shared OOB timeout counter; one expiry flag per configured limit,
// each raised when the count reaches that limit minus one.
module sata_oob_timer import sata_oob_pkg::*; #(
    parameter int unsigned LIMIT_INIT  = 100,
    parameter int unsigned LIMIT_ALIGN = 88
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       run,
    output logic [1:0] expired
);

    localparam int unsigned MAX_LIMIT = (LIMIT_INIT > LIMIT_ALIGN) ? LIMIT_INIT : LIMIT_ALIGN;
    localparam int W = (MAX_LIMIT > 1) ? $clog2(MAX_LIMIT) : 1;

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= count + W'(1);
        end
    end

    always_comb begin
        expired            = '0;
        expired[TMO_INIT]  = (count == W'(LIMIT_INIT - 1));
        expired[TMO_ALIGN] = (count == W'(LIMIT_ALIGN - 1));
    end

endmodule

// File: rtl/sata_oob_host_ctrl.sv
// SATA host OOB sequencer: COMRESET/COMINIT, COMWAKE handshake and ALIGN
// lock, with timeout retries and device-initiated reset handling.
module sata_oob_host_ctrl import sata_oob_pkg::*; #(
    parameter int unsigned CLKFREQ     = 100_000,
    parameter int unsigned INITTMO_US  = 10_000,
    parameter int unsigned ALIGNTMO_US = 880
) (
    input  logic               reset,
    input  logic               clk,
    input  logic               enable,
    input  logic               coder_ready,
    output logic               coder_cominit,
    output logic               coder_comwake,
    output logic               oobfinish,
    input  logic               rx_cominit,
    input  logic               rx_comwake,
    input  logic               rx_align,
    output logic               tx_align,
    output logic               link_up,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int unsigned INIT_LIMIT  = tmo_cycles(CLKFREQ, INITTMO_US);
    localparam int unsigned ALIGN_LIMIT = tmo_cycles(CLKFREQ, ALIGNTMO_US);

    oob_state_t         state;
    oob_state_t         state_next;
    logic               first;
    logic               timeout_hit;
    logic [RETRY_W-1:0] retry_next;
    logic               oobfinish_next;
    logic               tx_align_next;
    logic               link_up_next;
    logic               timer_clear;
    logic               timer_run;
    logic [1:0]         expired;

    sata_oob_timer #(
        .LIMIT_INIT  (INIT_LIMIT),
        .LIMIT_ALIGN (ALIGN_LIMIT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .run     (timer_run),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            first     <= 1'b0;
            retry_cnt <= '0;
            oobfinish <= 1'b0;
            tx_align  <= 1'b0;
            link_up   <= 1'b0;
        end else begin
            state     <= state_next;
            first     <= (state_next != state);
            retry_cnt <= retry_next;
            oobfinish <= oobfinish_next;
            tx_align  <= tx_align_next;
            link_up   <= link_up_next;
        end
    end

    // enable=0 beats a device COMINIT, which beats everything state-specific;
    // command pulses are only raised on the non-preempted paths.
    always_comb begin
        state_next    = state;
        coder_cominit = 1'b0;
        coder_comwake = 1'b0;
        timeout_hit   = 1'b0;
        retry_next    = retry_cnt;

        if (!enable) begin
            state_next = IDLE;
        end else if (rx_cominit && (state inside {WAKE_SEND, WAKE_WAIT, DEV_WAKE, ALIGN_WAIT, LINKUP})) begin
            state_next = RST_SEND;
        end else begin
            case (state)
                IDLE: state_next = RST_SEND;
                RST_SEND: begin
                    if (coder_ready) begin
                        coder_cominit = 1'b1;
                        state_next    = RST_WAIT;
                    end
                end
                RST_WAIT: if (!first && coder_ready) state_next = INIT_WAIT;
                INIT_WAIT: begin
                    if (rx_cominit) begin
                        state_next = WAKE_SEND;
                    end else if (expired[TMO_INIT]) begin
                        state_next  = RST_SEND;
                        timeout_hit = 1'b1;
                    end
                end
                WAKE_SEND: begin
                    if (coder_ready) begin
                        coder_comwake = 1'b1;
                        state_next    = WAKE_WAIT;
                    end
                end
                WAKE_WAIT: if (!first && coder_ready) state_next = DEV_WAKE;
                DEV_WAKE: begin
                    if (rx_comwake) begin
                        state_next = ALIGN_WAIT;
                    end else if (expired[TMO_INIT]) begin
                        state_next  = RST_SEND;
                        timeout_hit = 1'b1;
                    end
                end
                ALIGN_WAIT: begin
                    if (rx_align) begin
                        state_next = LINKUP;
                    end else if (expired[TMO_ALIGN]) begin
                        state_next  = RST_SEND;
                        timeout_hit = 1'b1;
                    end
                end
                LINKUP:  state_next = LINKUP;
                default: state_next = IDLE;
            endcase
        end

        if (timeout_hit && (retry_cnt != '1)) retry_next = retry_cnt + RETRY_W'(1);
        if ((state_next == LINKUP) && (state != LINKUP)) retry_next = '0;

        oobfinish_next = (state_next inside {ALIGN_WAIT, LINKUP});
        tx_align_next  = (state_next == LINKUP);
        link_up_next   = (state_next == LINKUP);
        timer_clear    = (state_next != state);
        timer_run      = (state inside {INIT_WAIT, DEV_WAKE, ALIGN_WAIT});
    end

endmodule

// File: tb/tb_sata_oob_host_ctrl.sv
// Self-checking bench for sata_oob_host_ctrl: protocol-level reference model,
// coder model (busy 20 cycles per command), scenario and random stimulus.
`timescale 1ns/1ps
module tb_sata_oob_host_ctrl;

    localparam int INIT_CYC   = 100;
    localparam int ALIGN_CYC  = 88;
    localparam int CODER_BUSY = 20;

    localparam int P_IDLE       = 0;
    localparam int P_RST_SEND   = 1;
    localparam int P_RST_WAIT   = 2;
    localparam int P_INIT_WAIT  = 3;
    localparam int P_WAKE_SEND  = 4;
    localparam int P_WAKE_WAIT  = 5;
    localparam int P_DEV_WAKE   = 6;
    localparam int P_ALIGN_WAIT = 7;
    localparam int P_LINKUP     = 8;

    logic       reset;
    logic       clk;
    logic       enable;
    logic       coder_ready = 1'b1;
    logic       coder_cominit;
    logic       coder_comwake;
    logic       oobfinish;
    logic       rx_cominit;
    logic       rx_comwake;
    logic       rx_align;
    logic       tx_align;
    logic       link_up;
    logic [7:0] retry_cnt;
    logic       hold_ready;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int busy = 0;
    int n_cominit = 0;
    int n_comwake = 0;
    int oob_run = 0;
    int last_oob_len = 0;
    int pulse_cyc[$];
    int pulse_retry[$];

    int m_phase = P_IDLE;
    int m_age = 0;
    int m_retry = 0;

    sata_oob_host_ctrl #(
        .CLKFREQ     (1000),
        .INITTMO_US  (100),
        .ALIGNTMO_US (88)
    ) dut (
        .reset         (reset),
        .clk           (clk),
        .enable        (enable),
        .coder_ready   (coder_ready),
        .coder_cominit (coder_cominit),
        .coder_comwake (coder_comwake),
        .oobfinish     (oobfinish),
        .rx_cominit    (rx_cominit),
        .rx_comwake    (rx_comwake),
        .rx_align      (rx_align),
        .tx_align      (tx_align),
        .link_up       (link_up),
        .retry_cnt     (retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check1(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Reference model: advances one protocol step per clock from the sampled inputs.
    always @(posedge clk) begin
        if (reset) begin
            m_phase = P_IDLE;
            m_age   = 0;
            m_retry = 0;
        end else begin
            int  nxt;
            bit  timed_out;
            nxt       = m_phase;
            timed_out = 1'b0;
            if (!enable) nxt = P_IDLE;
            else if (rx_cominit && m_phase >= P_WAKE_SEND) nxt = P_RST_SEND;
            else begin
                case (m_phase)
                    P_IDLE:       nxt = P_RST_SEND;
                    P_RST_SEND:   if (coder_ready) nxt = P_RST_WAIT;
                    P_RST_WAIT:   if (m_age > 0 && coder_ready) nxt = P_INIT_WAIT;
                    P_INIT_WAIT:  if (rx_cominit) nxt = P_WAKE_SEND;
                                  else if (m_age == INIT_CYC - 1) timed_out = 1'b1;
                    P_WAKE_SEND:  if (coder_ready) nxt = P_WAKE_WAIT;
                    P_WAKE_WAIT:  if (m_age > 0 && coder_ready) nxt = P_DEV_WAKE;
                    P_DEV_WAKE:   if (rx_comwake) nxt = P_ALIGN_WAIT;
                                  else if (m_age == INIT_CYC - 1) timed_out = 1'b1;
                    P_ALIGN_WAIT: if (rx_align) nxt = P_LINKUP;
                                  else if (m_age == ALIGN_CYC - 1) timed_out = 1'b1;
                    default: ;
                endcase
                if (timed_out) nxt = P_RST_SEND;
            end
            if (timed_out) m_retry = (m_retry < 255) ? m_retry + 1 : 255;
            if (nxt == P_LINKUP && m_phase != P_LINKUP) m_retry = 0;
            m_age   = (nxt == m_phase) ? m_age + 1 : 0;
            m_phase = nxt;
        end
    end

    // Coder model: ready drops for CODER_BUSY cycles after each command.
    always @(negedge clk) begin
        #1;
        coder_ready = (busy == 0) && !hold_ready;
    end

    // Per-cycle compare against the model, plus pulse bookkeeping.
    always @(negedge clk) begin
        #2;
        cycle++;
        if (!reset) begin
            check1("cominit", coder_cominit, enable && m_phase == P_RST_SEND && coder_ready);
            check1("comwake", coder_comwake, enable && m_phase == P_WAKE_SEND && coder_ready && !rx_cominit);
            check1("oobfinish", oobfinish, m_phase == P_ALIGN_WAIT || m_phase == P_LINKUP);
            check1("tx_align", tx_align, m_phase == P_LINKUP);
            check1("link_up", link_up, m_phase == P_LINKUP);
            check1("retry_cnt", retry_cnt, m_retry);
            check1("cmd_exclusive", coder_cominit & coder_comwake, 0);
        end
        if (coder_cominit === 1'b1) begin
            n_cominit++;
            pulse_cyc.push_back(cycle);
            pulse_retry.push_back(int'(retry_cnt));
        end
        if (coder_comwake === 1'b1) n_comwake++;
        if (coder_cominit === 1'b1 || coder_comwake === 1'b1) busy = CODER_BUSY;
        else if (busy > 0) busy--;
        if (oobfinish === 1'b1) oob_run++;
        else begin
            if (oob_run > 0) last_oob_len = oob_run;
            oob_run = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic look();
        #3;
    endtask

    task automatic wait_phase(input int p, input int budget, input string name);
        int k;
        k = 0;
        while (m_phase != p && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (m_phase != p) begin
            errors++;
            $display("[TB] FAIL wait_%s: phase %0d, expected %0d within %0d cycles", name, m_phase, p, budget);
        end
    endtask

    task automatic pulse_rx(input int which);
        case (which)
            0: rx_cominit = 1'b1;
            1: rx_comwake = 1'b1;
            default: rx_align = 1'b1;
        endcase
        tick(1);
        rx_cominit = 1'b0;
        rx_comwake = 1'b0;
        rx_align   = 1'b0;
    endtask

    task automatic applyStimulus();
        int base_ci, base_cw, q0, k;

        // Normal bring-up
        base_ci = n_cominit;
        base_cw = n_comwake;
        enable  = 1'b1;
        wait_phase(P_INIT_WAIT, 200, "normal_init");
        tick(5);
        pulse_rx(0);
        wait_phase(P_DEV_WAKE, 200, "normal_dev");
        tick(5);
        pulse_rx(1);
        wait_phase(P_ALIGN_WAIT, 50, "normal_align");
        tick(10);
        pulse_rx(2);
        wait_phase(P_LINKUP, 50, "normal_linkup");
        look();
        check1("normal_link_up", link_up, 1);
        check1("normal_oobfinish", oobfinish, 1);
        check1("normal_tx_align", tx_align, 1);
        check1("normal_retry", retry_cnt, 0);
        check1("normal_cominit_count", n_cominit - base_ci, 1);
        check1("normal_comwake_count", n_comwake - base_cw, 1);

        // Device-initiated reset while linked
        tick(3);
        base_ci = n_cominit;
        pulse_rx(0);
        look();
        check1("devrst_link_up", link_up, 0);
        check1("devrst_retry", retry_cnt, 0);
        check1("devrst_cominit", n_cominit - base_ci, 1);

        // ALIGN timeout
        wait_phase(P_INIT_WAIT, 200, "atmo_init");
        tick($urandom_range(2, 30));
        pulse_rx(0);
        wait_phase(P_DEV_WAKE, 200, "atmo_dev");
        tick($urandom_range(2, 30));
        pulse_rx(1);
        wait_phase(P_ALIGN_WAIT, 50, "atmo_align");
        base_ci = n_cominit;
        wait_phase(P_RST_SEND, 200, "atmo_rst");
        look();
        check1("atmo_oob_len", last_oob_len, 88);
        check1("atmo_cominit", n_cominit - base_ci, 1);
        check1("atmo_retry", retry_cnt, 1);

        // Abort during WAKE_WAIT
        wait_phase(P_INIT_WAIT, 200, "abort_init");
        tick(5);
        pulse_rx(0);
        wait_phase(P_WAKE_WAIT, 200, "abort_wwait");
        tick($urandom_range(2, 15));
        base_cw = n_comwake;
        enable  = 1'b0;
        tick(30);
        look();
        check1("abort_comwake", n_comwake - base_cw, 0);
        check1("abort_oobfinish", oobfinish, 0);
        tick(1);
        base_ci = n_cominit;
        enable  = 1'b1;
        wait_phase(P_RST_WAIT, 100, "abort_rst");
        look();
        check1("abort_fresh_cominit", n_cominit - base_ci, 1);

        // Reset pulse during DEV_WAKE, then re-enable with coder busy
        tick(1);
        wait_phase(P_INIT_WAIT, 200, "rst_init");
        tick(5);
        pulse_rx(0);
        wait_phase(P_DEV_WAKE, 200, "rst_dev");
        tick($urandom_range(3, 40));
        reset      = 1'b1;
        hold_ready = 1'b1;
        look();
        check1("rst_cominit", coder_cominit, 0);
        check1("rst_comwake", coder_comwake, 0);
        check1("rst_oobfinish", oobfinish, 0);
        check1("rst_tx_align", tx_align, 0);
        check1("rst_link_up", link_up, 0);
        check1("rst_retry", retry_cnt, 0);
        tick(1);
        reset   = 1'b0;
        base_ci = n_cominit;
        tick(30);
        look();
        check1("rst_hold_no_pulse", n_cominit - base_ci, 0);
        tick(1);
        hold_ready = 1'b0;
        tick(2);
        look();
        check1("rst_release_pulse", n_cominit - base_ci, 1);

        // No device: repeated COMRESET with ignored noise on comwake/align
        q0 = pulse_cyc.size() - 1;
        k  = 0;
        while (pulse_cyc.size() - q0 < 260 && k < 33000) begin
            @(negedge clk);
            rx_comwake = ($urandom_range(0, 4) == 0);
            rx_align   = ($urandom_range(0, 4) == 0);
            k++;
        end
        rx_comwake = 1'b0;
        rx_align   = 1'b0;
        look();
        check1("nodev_pulse_count", (pulse_cyc.size() - q0 >= 260) ? 1 : 0, 1);
        if (pulse_cyc.size() - q0 >= 260) begin
            for (int i = 1; i <= 3; i++) begin
                check1("nodev_period", pulse_cyc[q0 + i] - pulse_cyc[q0 + i - 1], 122);
                check1("nodev_retry_step", pulse_retry[q0 + i], i);
            end
            check1("nodev_retry_254", pulse_retry[q0 + 254], 254);
            check1("nodev_retry_sat", pulse_retry[q0 + 255], 255);
            check1("nodev_retry_hold", pulse_retry[q0 + 259], 255);
        end

        // Randomized traffic, checked cycle by cycle against the model
        for (int it = 0; it < 6; it++) begin
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                rx_cominit = ($urandom_range(0, 39) == 0);
                rx_comwake = ($urandom_range(0, 24) == 0);
                rx_align   = ($urandom_range(0, 19) == 0);
                enable     = ($urandom_range(0, 149) != 0);
            end
        end
        @(negedge clk);
        rx_cominit = 1'b0;
        rx_comwake = 1'b0;
        rx_align   = 1'b0;
        enable     = 1'b1;
        tick(2);
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        rx_cominit = 1'b0;
        rx_comwake = 1'b0;
        rx_align   = 1'b0;
        hold_ready = 1'b0;
        @(negedge clk);
        look();
        check1("init_cominit", coder_cominit, 0);
        check1("init_comwake", coder_comwake, 0);
        check1("init_oobfinish", oobfinish, 0);
        check1("init_link_up", link_up, 0);
        check1("init_retry", retry_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
